// File: rtl/riscv_ras_pkg.sv
// Shared types and constants for the return-address stack: operation encoding,
// RISC-V opcodes and the link-register numbers used by the push/pop hints.
package riscv_ras_pkg;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_POPPUSH
    } ras_op_e;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [4:0] REG_RA  = 5'd1;
    localparam logic [4:0] REG_T0  = 5'd5;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/riscv_ras_classify.sv
// Combinational jal/jalr classifier following the x1/x5 link-register hints.
module riscv_ras_classify
    import riscv_ras_pkg::*;
(
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output ras_op_e     ras_op
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rd_link;
    logic       rs1_link;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);

    always_comb begin
        ras_op = RAS_NONE;
        if (instr_valid) begin
            if (opcode == OP_JAL) begin
                if (rd_link) ras_op = RAS_PUSH;
            end else if (opcode == OP_JALR && funct3 == 3'b000) begin
                if (rd_link && !rs1_link) begin
                    ras_op = RAS_PUSH;
                end else if (!rd_link && rs1_link) begin
                    ras_op = RAS_POP;
                end else if (rd_link && rs1_link) begin
                    // Same link register on both sides is a plain call, not a coroutine swap.
                    ras_op = (rd != rs1) ? RAS_POPPUSH : RAS_PUSH;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_ras.sv
// Circular return-address stack with saturating count and a single {tos, count}
// checkpoint for undoing speculative updates.
module riscv_ras
    import riscv_ras_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic             pred_valid,
    output logic [XLEN-1:0]  pred_target,
    output logic [PTR_W:0]   count,
    output ras_op_e          ras_op
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  stack_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] ckpt_tos_q;
    logic [PTR_W:0]   ckpt_count_q;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  push_val;
    logic [PTR_W-1:0] tos_inc;

    riscv_ras_classify u_classify (
        .instr_valid (instr_valid),
        .instr       (instr),
        .ras_op      (ras_op)
    );

    assign push_val = pc + XLEN'(4);
    assign tos_inc  = tos_q + PTR_W'(1);

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_inc;
        if (ckpt_restore) begin
            tos_d   = ckpt_tos_q;
            count_d = ckpt_count_q;
        end else begin
            unique case (ras_op)
                RAS_PUSH: begin
                    tos_d   = tos_inc;
                    wr_en   = 1'b1;
                    count_d = (count_q == FULL) ? FULL : count_q + 1'b1;
                end
                RAS_POP: begin
                    if (count_q != '0) begin
                        tos_d   = tos_q - PTR_W'(1);
                        count_d = count_q - 1'b1;
                    end
                end
                RAS_POPPUSH: begin
                    wr_en = 1'b1;
                    if (count_q == '0) begin
                        // Nothing to replace, so fall back to a plain push.
                        tos_d   = tos_inc;
                        count_d = count_q + 1'b1;
                    end else begin
                        wr_idx = tos_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            tos_q        <= '0;
            count_q      <= '0;
            ckpt_tos_q   <= '0;
            ckpt_count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            if (wr_en) stack_q[wr_idx] <= push_val;
            if (ckpt_save && !ckpt_restore) begin
                ckpt_tos_q   <= tos_q;
                ckpt_count_q <= count_q;
            end
        end
    end

    assign count       = count_q;
    assign pred_valid  = (count_q != '0);
    assign pred_target = pred_valid ? stack_q[tos_q] : '0;

endmodule

// File: tb/tb_riscv_ras.sv
// Scoreboard bench for riscv_ras: each driven cycle queues its expected op and
// post-edge state; a checker pops and compares at every rising edge.
module tb_riscv_ras;
    import riscv_ras_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [31:0] I_JAL_RA    = 32'h008000ef;
    localparam logic [31:0] I_JAL_X0    = 32'h0080006f;
    localparam logic [31:0] I_JALR_RA3  = 32'h004180e7;
    localparam logic [31:0] I_RET       = 32'h00008067;
    localparam logic [31:0] I_JALR_RAT0 = 32'h000280e7;
    localparam logic [31:0] I_JALR_RARA = 32'h000080e7;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            instr_valid = 1'b0;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] pc = '0;
    logic            ckpt_save = 1'b0;
    logic            ckpt_restore = 1'b0;
    logic            pred_valid;
    logic [XLEN-1:0] pred_target;
    logic [PTR_W:0]  count;
    ras_op_e         ras_op;

    typedef struct {
        string       name;
        ras_op_e     op;
        int          cnt;
        logic        valid;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    riscv_ras #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .pred_valid   (pred_valid),
        .pred_target  (pred_target),
        .count        (count),
        .ras_op       (ras_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t    e;
        ras_op_e op_seen;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            op_seen = ras_op;
            #1;
            total++;
            if (op_seen !== e.op) begin
                bad++;
                $display("FAIL %s op: got %s want %s", e.name, op_seen.name(), e.op.name());
            end
            total++;
            if (int'(count) !== e.cnt) begin
                bad++;
                $display("FAIL %s count: got %0d want %0d", e.name, count, e.cnt);
            end
            total++;
            if (pred_valid !== e.valid) begin
                bad++;
                $display("FAIL %s pred_valid: got %0b want %0b", e.name, pred_valid, e.valid);
            end
            total++;
            if (pred_target !== e.tgt) begin
                bad++;
                $display("FAIL %s pred_target: got %h want %h", e.name, pred_target, e.tgt);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic sv, input logic rs,
                        input ras_op_e eop, input int ecnt, input logic ev,
                        input logic [31:0] etgt);
        exp_t e;
        rst = r;
        instr_valid = v;
        instr = ins;
        pc = p;
        ckpt_save = sv;
        ckpt_restore = rs;
        e.name = nm; e.op = eop; e.cnt = ecnt; e.valid = ev; e.tgt = etgt;
        sb.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b0;
        instr_valid = 1'b0;
        ckpt_save = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, RAS_NONE, 0, 1'b0, 32'h0);
    endtask

    task automatic push(input string nm, input logic [31:0] p, input int ecnt);
        step(nm, 1'b0, 1'b1, I_JAL_RA, p, 1'b0, 1'b0, RAS_PUSH, ecnt, 1'b1, p + 32'd4);
    endtask

    task automatic test_reset;
        do_reset("reset");
        total++;
        if (count !== '0 || pred_valid !== 1'b0 || pred_target !== '0) begin
            bad++;
            $display("FAIL reset_inline: got cnt=%0d v=%0b t=%h want 0/0/0",
                     count, pred_valid, pred_target);
        end
    endtask

    task automatic test_push_pop;
        push("jal_ra", 32'd0, 1);
        step("jalr_ra_x3", 1'b0, 1'b1, I_JALR_RA3, 32'd12, 1'b0, 1'b0, RAS_PUSH, 2, 1'b1, 32'd16);
        step("ret1", 1'b0, 1'b1, I_RET, 32'd16, 1'b0, 1'b0, RAS_POP, 1, 1'b1, 32'd4);
        step("ret2", 1'b0, 1'b1, I_RET, 32'd4, 1'b0, 1'b0, RAS_POP, 0, 1'b0, 32'd0);
        step("ret_empty", 1'b0, 1'b1, I_RET, 32'd4, 1'b0, 1'b0, RAS_POP, 0, 1'b0, 32'd0);
        step("jal_x0", 1'b0, 1'b1, I_JAL_X0, 32'd8, 1'b0, 1'b0, RAS_NONE, 0, 1'b0, 32'd0);
        step("invalid", 1'b0, 1'b0, I_JAL_RA, 32'd8, 1'b0, 1'b0, RAS_NONE, 0, 1'b0, 32'd0);
    endtask

    task automatic test_saturate;
        do_reset("sat_reset");
        for (int i = 0; i <= DEPTH; i++)
            push("sat_push", 32'(4 * i), (i + 1 > DEPTH) ? DEPTH : i + 1);
        for (int k = 0; k < DEPTH; k++) begin
            int c;
            c = DEPTH - 1 - k;
            step("sat_pop", 1'b0, 1'b1, I_RET, '0, 1'b0, 1'b0, RAS_POP, c, c != 0,
                 (c != 0) ? 32'(4 * DEPTH - 4 * k) : 32'd0);
        end
    endtask

    task automatic test_poppush;
        do_reset("pp_reset");
        push("pp_push0", 32'd0, 1);
        push("pp_push1", 32'd4, 2);
        step("poppush", 1'b0, 1'b1, I_JALR_RAT0, 32'd100, 1'b0, 1'b0, RAS_POPPUSH, 2, 1'b1,
             32'd104);
        step("ra_ra", 1'b0, 1'b1, I_JALR_RARA, 32'd200, 1'b0, 1'b0, RAS_PUSH, 3, 1'b1,
             32'd204);
        step("pop_after_pp", 1'b0, 1'b1, I_RET, '0, 1'b0, 1'b0, RAS_POP, 2, 1'b1, 32'd104);
        do_reset("pp_reset2");
        step("poppush_empty", 1'b0, 1'b1, I_JALR_RAT0, 32'd300, 1'b0, 1'b0, RAS_POPPUSH, 1,
             1'b1, 32'd304);
        step("pc_wrap", 1'b0, 1'b1, I_JAL_RA, 32'hffff_fffc, 1'b0, 1'b0, RAS_PUSH, 2, 1'b1,
             32'd0);
    endtask

    task automatic test_ckpt;
        do_reset("ck_reset");
        push("ck_push0", 32'd0, 1);
        push("ck_push1", 32'd4, 2);
        step("ck_save", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, RAS_NONE, 2, 1'b1, 32'd8);
        push("ck_push40", 32'd40, 3);
        step("ck_pop1", 1'b0, 1'b1, I_RET, '0, 1'b0, 1'b0, RAS_POP, 2, 1'b1, 32'd8);
        step("ck_pop2", 1'b0, 1'b1, I_RET, '0, 1'b0, 1'b0, RAS_POP, 1, 1'b1, 32'd4);
        step("ck_restore_push", 1'b0, 1'b1, I_JAL_RA, 32'd80, 1'b0, 1'b1, RAS_PUSH, 2, 1'b1,
             32'd8);
        push("ck_push60", 32'd60, 3);
        step("ck_save_restore", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, RAS_NONE, 2, 1'b1, 32'd8);
        push("ck_push70", 32'd70, 3);
        step("ck_restore2", 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, RAS_NONE, 2, 1'b1, 32'd8);
    endtask

    task automatic test_reset_mid;
        do_reset("mid_reset0");
        push("mid_push0", 32'd0, 1);
        push("mid_push1", 32'd4, 2);
        step("mid_save", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, RAS_NONE, 2, 1'b1, 32'd8);
        push("mid_push2", 32'd8, 3);
        step("mid_rst", 1'b1, 1'b1, I_JAL_RA, 32'd12, 1'b0, 1'b0, RAS_PUSH, 0, 1'b0, 32'd0);
        push("mid_jal", 32'd0, 1);
        step("mid_restore", 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, RAS_NONE, 0, 1'b0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_saturate();
        test_poppush();
        test_ckpt();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_ras.md
Name: riscv_ras

Overview:
- Parametrised return-address stack (RAS) for next-PC prediction of jal/jalr in the riscv core.
- Classifies each retired or fetched control instruction per the RISC-V link-register hint rules (x1/x5), then pushes PC+4, pops, or pop-then-pushes.
- Exposes the top-of-stack as a predicted return target.
- Supports one checkpoint/restore of stack state so the core can undo speculative updates on mispredict.

Parameters:
- XLEN, 32, address/data width of stored return addresses and pc.
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), width of top-of-stack pointer (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr/pc qualify an update this cycle.
- instr  in  32  instruction word to classify.
- pc  in  XLEN  address of instr; push value is pc+4.
- ckpt_save  in  1  capture {tos, count} into the checkpoint register.
- ckpt_restore  in  1  reload {tos, count} from the checkpoint register.
- pred_valid  out  1  count != 0.
- pred_target  out  XLEN  entry at tos (0 when empty).
- count  out  PTR_W+1  live entries, 0..DEPTH.
- ras_op  out  ras_op_e  classification of the current instr (combinational, for debug and bench).

Behaviour:
- Reset (rst=1 at the edge) clears all entries, tos, count and the checkpoint to 0.
  - pred_valid=0, pred_target=0, count=0 from the following cycle.
  - rst dominates every other input, including mid-sequence.
- Classification (combinational, only when instr_valid=1), with link = rd/rs1 in {x1, x5}:
  - jal (opcode 1101111): rd link -> PUSH; otherwise NONE.
  - jalr (opcode 1100111, funct3 000):
    - rd link, rs1 not link -> PUSH.
    - rd not link, rs1 link -> POP.
    - both link, rd != rs1 -> POPPUSH.
    - both link, rd == rs1 -> PUSH.
    - neither link -> NONE.
  - All other opcodes, or instr_valid=0 -> NONE.
- Updates (one per cycle, visible on outputs the cycle after the edge):
  - PUSH: tos <= tos+1 mod DEPTH; entry[new tos] <= pc+4; count <= min(count+1, DEPTH). Push when full wraps circularly and overwrites the oldest entry.
  - POP: if count != 0, tos <= tos-1 mod DEPTH and count <= count-1. Entry contents are not cleared. POP when empty is a no-op.
  - POPPUSH: entry[tos] <= pc+4; tos and count unchanged. If empty, behaves as PUSH (count becomes 1).
  - pc+4 wraps modulo 2^XLEN.
- Checkpoint:
  - ckpt_save latches the current (pre-update) {tos, count}.
  - ckpt_restore loads the checkpoint into {tos, count} and suppresses that cycle's instr update. Entries are not restored.
  - save and restore in the same cycle: restore applies, save is ignored.
- pred_target/pred_valid derive only from registered state (zero combinational path from instr).
- Latency: classify 0 cycles; stack update 1 cycle.

Decomposition:
- Shared package riscv/ras.svh:
  - typedef enum ras_op_e {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
  - Constants OP_JAL=7'b1101111, OP_JALR=7'b1100111, REG_RA=5'd1, REG_T0=5'd5.
- One combinational sub-module ras_classify (instr, instr_valid -> ras_op_e).
- riscv_ras holds the storage, pointer, count and checkpoint logic.

Test Plan:
1. Reset, then `jal ra, 8` (0x008000ef) at pc=0 -> ras_op=PUSH; next cycle count=1, pred_valid=1, pred_target=4.
2. From state 1, `jalr ra, x3, 4` (0x004180e7) at pc=12 -> PUSH, pred_target=16, count=2. Then `jalr x0, 0(ra)` (0x00008067) -> POP, pred_target=4, count=1. A second POP -> count=0, pred_valid=0. A third POP -> no change.
3. Push DEPTH+1 times with pcs 0,4,...,4*DEPTH -> count saturates at DEPTH; pred_target=4*DEPTH+4. DEPTH pops return 4*DEPTH+4 down to 8 (value 4 lost), then pred_valid=0.
4. Two PUSHes (targets 4, 8), then `jalr ra, 0(t0)` (0x000280e7) at pc=100 -> POPPUSH, pred_target=104, count=2. `jalr ra, 0(ra)` (0x000080e7) at pc=200 -> PUSH, pred_target=204, count=3.
5. ckpt_save at count=2 (top=8), then PUSH(pc=40) and POP x2. Then ckpt_restore together with a PUSH -> count=2, pred_target=8, the PUSH is ignored. save+restore in the same cycle -> restore applied.
6. rst asserted for 1 cycle in the middle of scenario 3 -> count=0, pred_valid=0, pred_target=0. A subsequent jal ra at pc=0 -> pred_target=4, count=1.
